maxpool_l1: RTL and testbench
=============================

# maxpool_l1

Layer-1 2x2 max-pool engine. Reads the 64x64 layer-0 result that the convolution engine wrote into layer memory, through the crd/caddr_rd/cdata_rd read port. Reduces each non-overlapping 2x2 window to its signed maximum and writes the 32x32 result into layer-1 memory through cwr/caddr_wr/cdata_wr. It is started by the top-level controller once layer 0 is complete, and reports completion back.

## Interface
- DATA_WIDTH, 20, pixel width (signed two's complement)
- ADDR_WIDTH, 12, memory address width
- IN_WIDTH, 64, layer-0 image side; output side is IN_WIDTH/2
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, all logic sampled on rising edge
- start  input  1  begin one full frame; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse after the last layer-1 write
- crd  output  1  layer-memory read strobe
- caddr_rd  output  ADDR_WIDTH  layer-0 read address = row*64 + col
- cdata_rd  input  DATA_WIDTH  read data, valid in the cycle after crd/caddr_rd
- cwr  output  1  layer-memory write strobe
- caddr_wr  output  ADDR_WIDTH  layer-1 write address = orow*32 + ocol
- cdata_wr  output  DATA_WIDTH  pooled value
- csel  output  3  3'b001 during reads (layer 0), 3'b011 during writes (layer 1), 3'b000 otherwise

## Operation
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE: start=1 goes to RD and clears orow/ocol/k. start=0 stays in IDLE.
- RD: lasts 4 cycles (k=0..3), with crd=1 each cycle.
  - k=0 reads (2*orow, 2*ocol); k=1 reads (2*orow, 2*ocol+1); k=2 reads (2*orow+1, 2*ocol); k=3 reads (2*orow+1, 2*ocol+1).
  - After k=3, go to WAIT.
- Running max:
  - The sample arriving for k=0 loads max_reg unconditionally.
  - Each later sample replaces max_reg only if it is strictly greater, using a signed DATA_WIDTH compare.
  - Ties keep the current value, so the result equals the tied value.
- WAIT: crd=0. The k=3 sample is compared combinationally, and the final max is registered into cdata_wr together with cwr=1, caddr_wr, and csel=3'b011 for the following cycle. Go to WR.
- WR: cwr=1 for exactly one cycle.
  - If this is window (31,31), go to DONE.
  - Otherwise advance ocol. On ocol wrap 31->0, increment orow. Go to RD.
- DONE: done=1 for one cycle, then IDLE with busy=0.
- start while not in IDLE is ignored.
- Output order is raster: ocol fastest, then orow.

## Timing
- Reset values: busy=0, done=0, crd=0, cwr=0, csel=3'b000, caddr_rd=0, caddr_wr=0, cdata_wr=0. State IDLE; counters and max_reg cleared.
- Reset mid-frame: the next cycle shows reset values. A later start restarts from window (0,0). No partial write completes after reset.
- Window cycle numbering: start sampled at edge 0.
  - Cycles 0..3: crd=1, address per k.
  - Read k data is valid in cycle k+1.
  - Cycle 4: WAIT, crd=0.
  - Cycle 5: WR, cwr=1.
  - Window n begins at cycle 6n.
- Frame timing:
  - The last write is at cycle 6143.
  - done is high in cycle 6144.
  - busy is low from cycle 6145.
- cwr and crd are never high in the same cycle.
- cdata_wr and caddr_wr hold their values outside WR; only cwr qualifies them.

## Structure
- Shared package conv_pkg:
  - DATA_WIDTH, ADDR_WIDTH, IMAGE_WIDTH constants.
  - csel codes CSEL_NONE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011.
  - Pool state enum.
- One sub-module, maxpool_addr_gen, holds the orow/ocol/k counters and produces caddr_rd, caddr_wr, and the last-window/last-k flags.
- The compare and the FSM stay in maxpool_l1.

## Test plan
- Reset: assert reset mid-frame at cycle 100 -> next cycle all outputs at reset values. Then pulse start -> first crd at caddr_rd=0.
- Single window: memory holds 5, 9, 3, 7 at addresses 0, 1, 64, 65; start -> cycle 5 shows cwr=1, caddr_wr=0, cdata_wr=9, csel=3'b011.
- Signed compare:
  - Window {0xFFFFF, 0xFFFFE, 0x80000, 0xFFFFD} -> cdata_wr=0xFFFFF (-1).
  - Window {0x80000, 0x00001, 0x00000, 0x00000} -> 0x00001.
  - Ties {4, 4, 4, 4} -> 4.
- Full frame with mem[a]=a:
  - 1024 writes in raster order, caddr_wr 0..1023; write n data = (2*orow+1)*64 + 2*ocol + 1.
  - Last write data 4095 at cycle 6143; done pulse at cycle 6144; busy low at cycle 6145.
- start held high throughout the frame -> exactly one frame is processed; no restart until IDLE is re-entered, then a new frame begins at the next cycle.
- Protocol checker throughout: crd & cwr never both high. csel=001 exactly when crd=1, 011 exactly when cwr=1, 000 otherwise.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, memory-select codes and pool FSM state type for the
// convolution/pooling engines.
package conv_pkg;

    localparam int DATA_WIDTH  = 20;
    localparam int ADDR_WIDTH  = 12;
    localparam int IMAGE_WIDTH = 64;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        POOL_IDLE,
        POOL_RD,
        POOL_WAIT,
        POOL_WR,
        POOL_DONE
    } pool_state_e;

endpackage

// File: rtl/maxpool_l1_if.sv
// Control and layer-memory bus of the layer-1 max-pool engine.
interface maxpool_l1_if #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = conv_pkg::ADDR_WIDTH
);

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  crd;
    logic [ADDR_WIDTH-1:0] caddr_rd;
    logic [DATA_WIDTH-1:0] cdata_rd;
    logic                  cwr;
    logic [ADDR_WIDTH-1:0] caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_wr;
    logic [2:0]            csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

endinterface

// File: rtl/maxpool_addr_gen.sv
// Window/sample counters for the 2x2 max-pool: produces layer-0 read and
// layer-1 write addresses plus last-sample and last-window flags.
module maxpool_addr_gen #(
    parameter int ADDR_WIDTH = 12,
    parameter int IN_WIDTH   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  k_inc,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] caddr_rd,
    output logic [ADDR_WIDTH-1:0] caddr_wr,
    output logic                  last_k,
    output logic                  last_win
);

    localparam int OUT_WIDTH = IN_WIDTH / 2;
    localparam int CW        = $clog2(OUT_WIDTH);
    localparam logic [CW-1:0]         LAST_IDX = CW'(OUT_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] IN_W_A   = ADDR_WIDTH'(IN_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OUT_W_A  = ADDR_WIDTH'(OUT_WIDTH);

    logic [CW-1:0] orow_q, orow_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic [1:0]    k_q, k_d;
    logic [CW:0]   row, col;

    always_comb begin
        orow_d = orow_q;
        ocol_d = ocol_q;
        k_d    = k_q;
        if (clr) begin
            orow_d = '0;
            ocol_d = '0;
            k_d    = '0;
        end else begin
            if (k_inc) begin
                k_d = k_q + 2'd1;
            end
            if (advance) begin
                k_d = '0;
                if (ocol_q == LAST_IDX) begin
                    ocol_d = '0;
                    orow_d = (orow_q == LAST_IDX) ? '0 : orow_q + 1'b1;
                end else begin
                    ocol_d = ocol_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            orow_q <= '0;
            ocol_q <= '0;
            k_q    <= '0;
        end else begin
            orow_q <= orow_d;
            ocol_q <= ocol_d;
            k_q    <= k_d;
        end
    end

    // k[1] selects the lower row of the window, k[0] the right column
    assign row      = {orow_q, k_q[1]};
    assign col      = {ocol_q, k_q[0]};
    assign caddr_rd = ADDR_WIDTH'(row) * IN_W_A + ADDR_WIDTH'(col);
    assign caddr_wr = ADDR_WIDTH'(orow_q) * OUT_W_A + ADDR_WIDTH'(ocol_q);
    assign last_k   = (k_q == 2'd3);
    assign last_win = (orow_q == LAST_IDX) && (ocol_q == LAST_IDX);

endmodule

// File: rtl/maxpool_l1.sv
// Layer-1 2x2 max-pool engine: reads the layer-0 image, keeps a signed
// running max per window and writes the pooled image to layer-1 memory.
module maxpool_l1 #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = conv_pkg::ADDR_WIDTH,
    parameter int IN_WIDTH   = conv_pkg::IMAGE_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    maxpool_l1_if.master  bus
);

    import conv_pkg::*;

    pool_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] cdata_wr_q, cdata_wr_d;
    logic [ADDR_WIDTH-1:0] caddr_wr_q, caddr_wr_d;
    logic [ADDR_WIDTH-1:0] addr_wr;
    logic                  clr, k_inc, advance;
    logic                  last_k, last_win;
    logic                  greater;

    maxpool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IN_WIDTH   (IN_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .k_inc    (k_inc),
        .advance  (advance),
        .caddr_rd (bus.caddr_rd),
        .caddr_wr (addr_wr),
        .last_k   (last_k),
        .last_win (last_win)
    );

    assign greater = $signed(bus.cdata_rd) > $signed(max_q);

    // Read data lags the address by one cycle: in RD the sample for k-1 is
    // on cdata_rd, and the k=3 sample arrives during WAIT.
    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        cdata_wr_d = cdata_wr_q;
        caddr_wr_d = caddr_wr_q;
        clr        = 1'b0;
        k_inc      = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            POOL_IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = POOL_RD;
                end
            end
            POOL_RD: begin
                k_inc = 1'b1;
                if (bus.caddr_rd[0] && !last_k && !bus.caddr_rd[IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 0]) begin
                    max_d = bus.cdata_rd;
                end else if (!(bus.caddr_rd[0] == 1'b0 && !last_k && !bus.caddr_rd[$clog2(IN_WIDTH)]) && greater) begin
                    max_d = bus.cdata_rd;
                end
                if (last_k) begin
                    state_d = POOL_WAIT;
                end
            end
            POOL_WAIT: begin
                cdata_wr_d = greater ? bus.cdata_rd : max_q;
                caddr_wr_d = addr_wr;
                state_d    = POOL_WR;
            end
            POOL_WR: begin
                if (last_win) begin
                    state_d = POOL_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = POOL_RD;
                end
            end
            POOL_DONE: begin
                state_d = POOL_IDLE;
            end
            default: begin
                state_d = POOL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= POOL_IDLE;
            max_q      <= '0;
            cdata_wr_q <= '0;
            caddr_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            cdata_wr_q <= cdata_wr_d;
            caddr_wr_q <= caddr_wr_d;
        end
    end

    assign bus.busy     = (state_q != POOL_IDLE);
    assign bus.done     = (state_q == POOL_DONE);
    assign bus.crd      = (state_q == POOL_RD);
    assign bus.cwr      = (state_q == POOL_WR);
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.csel     = (state_q == POOL_RD) ? CSEL_L0 :
                          (state_q == POOL_WR) ? CSEL_L1 : CSEL_NONE;

endmodule

// File: tb/tb_maxpool_l1.sv
// Self-checking bench for maxpool_l1: behavioural layer memory, per-cycle
// timing/address/data checks against a window-max reference model.
module tb_maxpool_l1;

    localparam int DW = 20;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maxpool_l1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    maxpool_l1 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IN_WIDTH   (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [4096];
    logic [DW-1:0] got_win [4];
    logic [DW-1:0] last_wr;
    int vectors     = 0;
    int miscompares = 0;

    always @(posedge clk) begin
        if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("crd_and_cwr", {31'd0, bus.crd & bus.cwr}, 32'd0);
        chk("csel", {29'd0, bus.csel},
            bus.crd ? 32'd1 : (bus.cwr ? 32'd3 : 32'd0));
    end

    function automatic logic [DW-1:0] ref_max(input int orow, input int ocol);
        logic signed [DW-1:0] m, v;
        int base;
        base = 2 * orow * 64 + 2 * ocol;
        m = mem[base];
        v = mem[base + 1];  if (v > m) m = v;
        v = mem[base + 64]; if (v > m) m = v;
        v = mem[base + 65]; if (v > m) m = v;
        return m;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     {31'd0, bus.busy}, 0);
        chk({tag, "_done"},     {31'd0, bus.done}, 0);
        chk({tag, "_crd"},      {31'd0, bus.crd}, 0);
        chk({tag, "_cwr"},      {31'd0, bus.cwr}, 0);
        chk({tag, "_csel"},     {29'd0, bus.csel}, 0);
        chk({tag, "_caddr_rd"}, {20'd0, bus.caddr_rd}, 0);
        chk({tag, "_caddr_wr"}, {20'd0, bus.caddr_wr}, 0);
        chk({tag, "_cdata_wr"}, {12'd0, bus.cdata_wr}, 0);
    endtask

    // Returns in cycle 6145 of the frame (first idle cycle).
    task automatic run_frame(input bit hold_start);
        logic [DW-1:0] exp [1024];
        int n, p, orow, ocol;
        for (int i = 0; i < 1024; i++) exp[i] = ref_max(i / 32, i % 32);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        for (int c = 0; c <= 6145; c++) begin
            if (c < 6144) begin
                n = c / 6; p = c % 6; orow = n / 32; ocol = n % 32;
                chk("busy", {31'd0, bus.busy}, 1);
                chk("done", {31'd0, bus.done}, 0);
                chk("crd",  {31'd0, bus.crd}, (p < 4) ? 1 : 0);
                chk("cwr",  {31'd0, bus.cwr}, (p == 5) ? 1 : 0);
                if (p < 4)
                    chk("caddr_rd", {20'd0, bus.caddr_rd}, (2 * orow + p / 2) * 64 + 2 * ocol + p % 2);
                if (p == 5) begin
                    chk("caddr_wr", {20'd0, bus.caddr_wr}, n);
                    chk("cdata_wr", {12'd0, bus.cdata_wr}, {12'd0, exp[n]});
                    if (n < 4) got_win[n] = bus.cdata_wr;
                    last_wr = bus.cdata_wr;
                end else if (p == 0 && n > 0) begin
                    chk("cdata_hold", {12'd0, bus.cdata_wr}, {12'd0, exp[n - 1]});
                end
            end else if (c == 6144) begin
                chk("done_pulse", {31'd0, bus.done}, 1);
                chk("busy_done",  {31'd0, bus.busy}, 1);
                chk("cdata_hold_done", {12'd0, bus.cdata_wr}, {12'd0, exp[1023]});
            end else begin
                chk("done_end", {31'd0, bus.done}, 0);
                chk("busy_end", {31'd0, bus.busy}, 0);
                chk("crd_end",  {31'd0, bus.crd}, 0);
            end
            if (c < 6145) @(negedge clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.cdata_rd = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // Frame A: mem[a] = a
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a);
        run_frame(1'b0);
        chk("last_wr_data", {12'd0, last_wr}, 4095);

        // Frame B: random data with planted corner windows, start held high
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        mem[0] = 5;        mem[1] = 9;        mem[64] = 3;       mem[65] = 7;
        mem[2] = 'hFFFFF;  mem[3] = 'hFFFFE;  mem[66] = 'h80000; mem[67] = 'hFFFFD;
        mem[4] = 'h80000;  mem[5] = 'h00001;  mem[68] = 0;       mem[69] = 0;
        mem[6] = 4;        mem[7] = 4;        mem[70] = 4;       mem[71] = 4;
        run_frame(1'b1);
        chk("win_basic",  {12'd0, got_win[0]}, 9);
        chk("win_neg",    {12'd0, got_win[1]}, 'hFFFFF);
        chk("win_minpos", {12'd0, got_win[2]}, 1);
        chk("win_tie",    {12'd0, got_win[3]}, 4);

        // Held start restarts right after IDLE; abort it with reset at cycle 100
        @(negedge clk);
        chk("restart_crd",  {31'd0, bus.crd}, 1);
        chk("restart_addr", {20'd0, bus.caddr_rd}, 0);
        chk("restart_busy", {31'd0, bus.busy}, 1);
        repeat (100) @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {31'd0, bus.busy}, 0);

        // Frame C: fresh random data from window (0,0)
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        run_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
